// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction
// classes, ALU/immediate/writeback selects, opcodes and fault codes.
package mcu_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } iclass_t;

  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_XOR   = 5'b00010;
  localparam logic [4:0] ALU_AND   = 5'b00011;
  localparam logic [4:0] ALU_OR    = 5'b00100;
  localparam logic [4:0] ALU_SLL   = 5'b00110;
  localparam logic [4:0] ALU_SRL   = 5'b00111;
  localparam logic [4:0] ALU_SRA   = 5'b01000;
  localparam logic [4:0] ALU_SLT   = 5'b01001;
  localparam logic [4:0] ALU_SLTU  = 5'b01010;
  localparam logic [4:0] ALU_PASSB = 5'b01011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  // alt selects SUB/SRA; callers must only raise it where that is legal
  function automatic logic [4:0] alu_sel(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // status = {V,C,N,Z}; C follows the no-borrow convention of the SUB compare
  function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] status);
    logic lt;
    lt = status[1] ^ status[3];
    case (funct3)
      3'b000:  return status[0];
      3'b001:  return !status[0];
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return !status[2];
      3'b111:  return status[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of opcode/funct3/funct7 into instruction class,
// ALU operation, immediate format and an illegal-instruction flag.
module instr_decoder
  import mcu_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output iclass_t    cls,
  output logic [4:0] aluop,
  output logic [2:0] immsrc,
  output logic       illegal
);

  logic f7_zero, f7_alt;

  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  always_comb begin
    cls     = C_ALU;
    aluop   = ALU_ADD;
    immsrc  = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        aluop   = alu_sel(funct3, funct7[5]);
        illegal = !(f7_zero || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OP_I: begin
        // upper immediate bits only carry meaning for the shift forms
        aluop   = alu_sel(funct3, funct7[5] && (funct3 == 3'b101));
        illegal = (funct3 == 3'b001 || funct3 == 3'b101) &&
                  !(f7_zero || (f7_alt && funct3 == 3'b101));
      end
      OP_LOAD: begin
        cls     = C_LOAD;
        illegal = (funct3 != 3'b010);
      end
      OP_STORE: begin
        cls     = C_STORE;
        immsrc  = IMM_S;
        illegal = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        cls     = C_BRANCH;
        aluop   = ALU_SUB;
        immsrc  = IMM_B;
        illegal = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OP_JAL: begin
        cls    = C_JAL;
        immsrc = IMM_J;
      end
      OP_JALR: begin
        cls     = C_JALR;
        illegal = (funct3 != 3'b000);
      end
      OP_LUI: begin
        cls    = C_LUI;
        aluop  = ALU_PASSB;
        immsrc = IMM_U;
      end
      OP_AUIPC: begin
        cls    = C_AUIPC;
        immsrc = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback, with memory-acknowledge timeout and a sticky trap state.
//
//   state  | meaning
//   FETCH  | imem_req high until imem_ack; IR loads on the ack cycle
//   DECODE | one idle cycle; illegal encodings divert to TRAP
//   EXEC   | ALU controls per class; branches update PC here
//   MEM    | dmem_req high until dmem_ack; stores finish here
//   WB     | register write plus PC update, one cycle
//   TRAP   | fault raised, all strobes off, left only by rst
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ALUOP_W     = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    instr,
  input  logic [3:0]         status,
  output logic               imem_req,
  input  logic               imem_ack,
  output logic               dmem_req,
  input  logic               dmem_ack,
  output logic               ir_we,
  output logic               pc_we,
  output logic               regRW,
  output logic               mRW,
  output logic               ALUsrc,
  output logic               pcsrc,
  output logic [2:0]         immsrc,
  output logic [1:0]         wb,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               fault,
  output logic [1:0]         fault_code
);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [1:0]  fault_code_q;
  iclass_t     cls;
  logic [4:0]  dec_aluop;
  logic [2:0]  dec_immsrc;
  logic        illegal, timeout, taken, is_link;

  instr_decoder u_dec (
    .opcode  (instr[6:0]),
    .funct3  (instr[14:12]),
    .funct7  (instr[31:25]),
    .cls     (cls),
    .aluop   (dec_aluop),
    .immsrc  (dec_immsrc),
    .illegal (illegal)
  );

  assign timeout = (wait_cnt == 16'(MEM_TIMEOUT));
  assign taken   = branch_taken(instr[14:12], status);
  assign is_link = (cls == C_JAL) || (cls == C_JALR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_FETCH;
      wait_cnt     <= '0;
      fault_code_q <= FC_NONE;
    end else begin
      case (state)
        S_FETCH: begin
          // an ack in the timeout cycle still wins
          if (imem_ack) begin
            state <= S_DECODE;
          end else if (timeout) begin
            state        <= S_TRAP;
            fault_code_q <= FC_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_DECODE: begin
          if (illegal) begin
            state        <= S_TRAP;
            fault_code_q <= FC_ILLEGAL;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (cls == C_BRANCH)                     state <= S_FETCH;
          else if (cls == C_LOAD || cls == C_STORE) state <= S_MEM;
          else                                      state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ack) begin
            wait_cnt <= '0;
            state    <= (cls == C_STORE) ? S_FETCH : S_WB;
          end else if (timeout) begin
            state        <= S_TRAP;
            fault_code_q <= FC_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end
        default: state <= S_TRAP;
      endcase
    end
  end

  // rst gates every output so no strobe survives into the reset cycle
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    regRW      = 1'b0;
    mRW        = 1'b0;
    ALUsrc     = 1'b0;
    pcsrc      = 1'b1;
    immsrc     = IMM_I;
    wb         = WB_ALU;
    ALUop      = '0;
    fault      = 1'b0;
    fault_code = FC_NONE;
    if (!rst) begin
      fault_code = fault_code_q;
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          ALUsrc = (cls == C_BRANCH) || (cls == C_ALU && instr[6:0] == OP_R);
          immsrc = dec_immsrc;
          ALUop  = ALUOP_W'(dec_aluop);
          if (cls == C_BRANCH) begin
            pc_we = 1'b1;
            pcsrc = !taken;
          end else if (is_link) begin
            pcsrc = 1'b0;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          mRW      = (cls == C_STORE);
          pc_we    = (cls == C_STORE) && dmem_ack;
        end
        S_WB: begin
          regRW = 1'b1;
          pc_we = 1'b1;
          pcsrc = !is_link;
          if (cls == C_LOAD)  wb = WB_MEM;
          else if (is_link)   wb = WB_PC4;
        end
        S_TRAP: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter XLEN, 32, instruction/datapath width; only 32 is legal in this revision.
REQ-002 Parameter ALUOP_W, 5, ALU opcode width.
REQ-003 Parameter MEM_TIMEOUT, 255, maximum wait cycles for any memory acknowledge; legal range 1..65535.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr  in  XLEN  instruction register contents, valid from DECODE onward.
REQ-007 status  in  4  ALU flags {V,C,N,Z} = [3:0] = {3,2,1,0}, valid in EXEC.
REQ-008 imem_req / imem_ack  out / in  1 / 1  instruction-fetch handshake.
REQ-009 dmem_req / dmem_ack  out / in  1 / 1  data-memory handshake.
REQ-010 ir_we, pc_we  out  1  instruction-register load; PC update.
REQ-011 regRW, mRW  out  1  register-file write; memory write (1) or read (0).
REQ-012 ALUsrc  out  1  0 = immediate, 1 = B operand.
REQ-013 pcsrc  out  1  0 = branch/jump target, 1 = PC+4.
REQ-014 immsrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J.
REQ-015 wb  out  2  00 ALU result, 01 memory data, 10 PC+4.
REQ-016 ALUop  out  ALUOP_W  ADD 00000, SUB 00001, XOR 00010, AND 00011, OR 00100, SLL 00110, SRL 00111, SRA 01000, SLT 01001, SLTU 01010, PASSB 01011.
REQ-017 fault, fault_code  out  1, 2  sticky trap flag; 01 illegal instruction, 10 memory timeout.

Function
REQ-018 FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-019 FETCH holds imem_req=1 until imem_ack; on the ack cycle, ir_we=1 and next state is DECODE.
REQ-020 DECODE lasts 1 cycle; all outputs except the FSM state are inactive; an illegal opcode/funct3/funct7 goes to TRAP, otherwise EXEC.
REQ-021 Legal set: R (add, sub, sll, slt, sltu, xor, srl, sra, or, and), I-ALU (same set minus sub), LW, SW, BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR, LUI, AUIPC.
REQ-022 R-type funct7 SHALL be 0000000, or 0100000 only for sub/sra; any other value is illegal.
REQ-023 EXEC drives ALUsrc, immsrc and ALUop per decoded class; branches compare with SUB.
REQ-024 Branch taken conditions: EQ Z, NE !Z, LT N^V, GE !(N^V), LTU !C, GEU C.
REQ-025 Branch/JAL/JALR target: pcsrc=0 when taken, pcsrc=1 otherwise.
REQ-026 Branch in EXEC: pc_we=1 then FETCH, for 3 cycles total at zero wait.
REQ-027 LW/SW in EXEC compute the address (ADD, imm I/S) and then go to MEM.
REQ-028 MEM holds dmem_req=1 and mRW=SW; on dmem_ack, SW asserts pc_we and goes to FETCH, LW goes to WB.
REQ-029 WB asserts regRW=1 and pc_we=1 for exactly 1 cycle, then goes to FETCH.
REQ-030 WB selects wb: 01 for LW, 10 for JAL/JALR, 00 otherwise.
REQ-031 Zero-wait latency: ALU/LUI/AUIPC/JAL/JALR 4 cycles; SW 4; LW 5; branch 3.
REQ-032 A wait counter clears on entry to FETCH or MEM and increments each cycle without ack.
REQ-033 When the wait counter reaches MEM_TIMEOUT without ack, next state is TRAP with fault_code=10.
REQ-034 An ack on the same cycle the counter reaches MEM_TIMEOUT counts as success.
REQ-035 TRAP: fault=1, all write/request outputs are 0, and the FSM stays in TRAP until rst.
REQ-036 An ack received outside its matching request state is ignored.
REQ-037 Outputs are decoded from registered state plus instr/status only; there are no latches and every output has a default in all states.

Reset
REQ-038 While rst=1: state FETCH, wait counter 0, fault=0, fault_code=00, imem_req=0, and all other outputs 0 except pcsrc=1.
REQ-039 rst asserted mid-instruction aborts it at the next edge; no write strobe is asserted in the cycle after rst is sampled.
REQ-040 The first imem_req rises in the first cycle after rst deasserts.

Structure
REQ-041 Package mcu_pkg holds the state enum, the ALUop, immsrc and wb encodings, opcode constants and fault codes.
REQ-042 Sub-module instr_decoder (combinational) maps instr to class, ALUop, immsrc and illegal; the FSM is in the top.

Verification
REQ-043 ADD x3,x1,x2 (0x002081B3), acks immediate -> states FETCH/DECODE/EXEC/WB, regRW=1 and pc_we=1 in cycle 4, ALUop=00000, wb=00.
REQ-044 LW (0x0000A183) with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, then WB with wb=01 and regRW=1, 8 cycles total.
REQ-045 BLT with status N=1, V=0 -> pcsrc=0 and pc_we=1 in cycle 3; the same instruction with N=V=1 -> pcsrc=1.
REQ-046 Opcode 0x7F, or funct7 0x20 on xor -> TRAP, fault=1, fault_code=01, no regRW.
REQ-047 MEM_TIMEOUT=4 and imem_ack never asserted -> TRAP after 4 wait cycles with fault_code=10; a later rst returns to FETCH with fault=0.
REQ-048 rst pulsed during MEM of SW -> no mRW/dmem_req the following cycle, then a clean restart in FETCH.
